// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: character framing, receiver FSM state encoding and
// default baud-divisor constants. The transmitter uses the same constants.
package uart_rx_ctrl_pkg;

  localparam int unsigned UartDataBits          = 8;
  localparam int unsigned UartClkFreqHz         = 100_000_000;
  localparam int unsigned UartDefaultBaud       = 115_200;
  // 100 MHz / 115200 baud, truncated to 868.
  localparam int unsigned UartDefaultClksPerBit = UartClkFreqHz / UartDefaultBaud;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO, usable on both UART directions.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   push_i/wdata_i  write request and data
//   pop_i         remove the head entry (ignored when empty)
//   rdata_o       head entry, valid while empty_o is low
//   full_o, empty_o, count_o  occupancy status
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i & ~empty_o;
    push_ok  = push_i & (~full_o | pop_ok);
    // Depth is a power of two, so pointers wrap by plain overflow.
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver with FWFT receive FIFO and sticky error flags.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   uart_rx      asynchronous serial input, idle high
//   rx_en        allows detection of new start bits
//   rd_en        pop the FIFO head
//   err_clr      clear frame_err / overrun_err (a coincident new error wins)
//   rx_data      FIFO head byte, valid while rx_valid
//   rx_valid     FIFO not empty
//   rx_count     FIFO occupancy
//   rx_busy      a frame is being received
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: received byte dropped because the FIFO was full
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartDefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          rx_en,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [UartDataBits-1:0]       rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfBitLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast     = CntW'(CLKS_PER_BIT - 1);

  uart_rx_state_e          state_q, state_d;
  logic                    sync1_q, rx_s_q, rx_prev_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [UartDataBits-1:0] shift_q, shift_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_err_q, overrun_err_d;

  logic fall_edge, half_hit, bit_hit;
  logic byte_push, frame_set, overrun_set;
  logic fifo_full, fifo_empty;

  assign fall_edge = rx_prev_q & ~rx_s_q;
  assign half_hit  = (cnt_q == HalfBitLast);
  assign bit_hit   = (cnt_q == BitLast);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync1_q       <= uart_rx;
      rx_s_q        <= sync1_q;
      rx_prev_q     <= rx_s_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rx_en && fall_edge) state_d = StStart;
      // High at mid-start means the falling edge was a glitch.
      StStart: if (half_hit) state_d = rx_s_q ? StIdle : StData;
      StData:  if (bit_hit && bit_idx_q == 3'(UartDataBits - 1)) state_d = StStop;
      StStop:  if (bit_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bit timing counter and LSB-first shift register.
  always_comb begin
    cnt_d     = cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: cnt_d = '0;
      StStart: begin
        if (half_hit) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_hit) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[UartDataBits-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop:  if (bit_hit) cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  // Outputs and error flags.
  always_comb begin
    rx_busy       = (state_q != StIdle);
    byte_push     = (state_q == StStop) & bit_hit & rx_s_q;
    frame_set     = (state_q == StStop) & bit_hit & ~rx_s_q;
    // A full FIFO is never empty, so rd_en alone decides whether room is made.
    overrun_set   = byte_push & fifo_full & ~rd_en;
    frame_err_d   = frame_set | (frame_err_q & ~err_clr);
    overrun_err_d = overrun_set | (overrun_err_q & ~err_clr);
  end

  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_valid    = ~fifo_empty;

  uart_rx_fifo #(
    .Width (UartDataBits),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (byte_push),
    .wdata_i (shift_q),
    .pop_i   (rd_en),
    .rdata_o (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rx_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed 8N1 frames, a frame-level reference model
// (byte queue + sticky flags + busy window) compared every cycle, and literal
// spot checks of hand-computed values.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  // Start bit driven just after cycle c: two sync stages plus the edge-detect
  // cycle put the FSM in START at c+3; half a bit, eight data bits and the
  // stop bit follow, and the FIFO write lands one edge after the stop sample.
  localparam int unsigned LAT        = 3 + CPB / 2 + 9 * CPB;
  localparam int unsigned GLITCH_END = 3 + CPB / 2;

  logic       clk = 1'b0;
  logic       rst, uart_rx, rx_en, rd_en, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun_err;
  logic [2:0] rx_count;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_en       (rx_en),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_count    (rx_count),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    bit          ok;
  } frame_ev_t;

  frame_ev_t   ev_q[$];
  logic [7:0]  mq[$];
  bit          m_ferr = 0, m_oerr = 0;
  int unsigned cyc = 0, busy_from = 0, busy_to = 0, last_ev_cyc = 0;
  int          n_chk = 0, n_pass = 0;
  bit          chk_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model, advanced on every rising edge.
  initial begin
    frame_ev_t e;
    bit pop_ok, push, fset, oset;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        ev_q.delete();
        m_ferr    = 0;
        m_oerr    = 0;
        busy_from = 0;
        busy_to   = 0;
      end else begin
        pop_ok = rd_en && mq.size() != 0;
        push   = 0;
        fset   = 0;
        if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
          e = ev_q.pop_front();
          if (e.ok) push = 1;
          else fset = 1;
        end
        oset = push && mq.size() == DEPTH && !pop_ok;
        if (pop_ok) void'(mq.pop_front());
        if (push && !oset) mq.push_back(e.data);
        m_ferr = fset | (m_ferr & !err_clr);
        m_oerr = oset | (m_oerr & !err_clr);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
        chk("rx_count", 32'(rx_count), 32'(mq.size()));
        chk("rx_busy", 32'(rx_busy), 32'(cyc >= busy_from && cyc < busy_to));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("overrun_err", 32'(overrun_err), 32'(m_oerr));
        if (mq.size() != 0) chk("rx_data", 32'(rx_data), 32'(mq[0]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic note_frame(input logic [7:0] d, input bit stop_ok);
    if (rx_en) begin
      ev_q.push_back('{cyc + LAT, d, stop_ok});
      last_ev_cyc = cyc + LAT;
      busy_from   = cyc + 3;
      busy_to     = cyc + LAT;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    note_frame(d, stop_ok);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  // Pulse rd_en (which=0) or err_clr (which=1) for the cycle ending at edge target.
  task automatic pulse_at(input int unsigned target, input bit which);
    while (cyc < target - 1) tick(1);
    if (which) err_clr = 1'b1;
    else rd_en = 1'b1;
    tick(1);
    err_clr = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] d);
    chk("pop valid", 32'(rx_valid), 32'h1);
    chk("pop data", 32'(rx_data), 32'(d));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; uart_rx = 1'b1; rx_en = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    tick(1);
    chk_en = 1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("reset rx_valid", 32'(rx_valid), 32'h0);
    chk("reset rx_count", 32'(rx_count), 32'h0);
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset rx_busy", 32'(rx_busy), 32'h0);

    // Single frame then pop.
    send_frame(8'hA5, 1'b1);
    chk("a5 valid", 32'(rx_valid), 32'h1);
    chk("a5 data", 32'(rx_data), 32'hA5);
    chk("a5 count", 32'(rx_count), 32'h1);
    chk("a5 frame_err", 32'(frame_err), 32'h0);
    pop_expect(8'hA5);
    chk("a5 empty after pop", 32'(rx_count), 32'h0);

    // Short low pulse: rejected at the mid-start sample.
    busy_from = cyc + 3;
    busy_to   = cyc + GLITCH_END;
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    chk("glitch busy", 32'(rx_busy), 32'h1);
    tick(30);
    chk("glitch idle", 32'(rx_busy), 32'h0);
    chk("glitch count", 32'(rx_count), 32'h0);
    chk("glitch frame_err", 32'(frame_err), 32'h0);

    // Framing error, clear, and clear colliding with a new error.
    send_frame(8'h3C, 1'b0);
    tick(4);
    chk("ferr set", 32'(frame_err), 32'h1);
    chk("ferr count", 32'(rx_count), 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ferr cleared", 32'(frame_err), 32'h0);
    fork
      send_frame(8'h3C, 1'b0);
      begin
        tick(1);
        pulse_at(last_ev_cyc, 1'b1);
      end
    join
    tick(CPB);
    chk("ferr set wins over clr", 32'(frame_err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;

    // Overrun: five frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    tick(2);
    chk("ovr count", 32'(rx_count), 32'h4);
    chk("ovr flag", 32'(overrun_err), 32'h1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    chk("ovr drained", 32'(rx_valid), 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ovr cleared", 32'(overrun_err), 32'h0);
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(1);
        pulse_at(last_ev_cyc, 1'b0);
      end
    join
    tick(2);
    chk("full push+pop count", 32'(rx_count), 32'h4);
    chk("full push+pop no ovr", 32'(overrun_err), 32'h0);
    for (int i = 2; i <= 5; i++) pop_expect(8'(i));

    // Reset mid-frame with state to clear.
    send_frame(8'h3C, 1'b0);
    tick(CPB);
    send_frame(8'h11, 1'b1);
    tick(2);
    chk("pre-rst frame_err", 32'(frame_err), 32'h1);
    chk("pre-rst count", 32'(rx_count), 32'h1);
    note_frame(8'h77, 1'b1);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'b1;
      tick(CPB);
    end
    uart_rx = 1'b0;
    tick(CPB / 2);
    chk("mid-frame busy", 32'(rx_busy), 32'h1);
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(2);
    chk("rst valid", 32'(rx_valid), 32'h0);
    chk("rst count", 32'(rx_count), 32'h0);
    chk("rst data", 32'(rx_data), 32'h0);
    chk("rst busy", 32'(rx_busy), 32'h0);
    chk("rst frame_err", 32'(frame_err), 32'h0);
    chk("rst overrun_err", 32'(overrun_err), 32'h0);
    rst = 1'b0;
    tick(5);
    send_frame(8'h5A, 1'b1);
    tick(2);
    chk("post-rst data", 32'(rx_data), 32'h5A);
    chk("post-rst count", 32'(rx_count), 32'h1);
    pop_expect(8'h5A);

    // Receiver enable gating.
    rx_en = 1'b0;
    send_frame(8'hFF, 1'b1);
    tick(4);
    chk("disabled valid", 32'(rx_valid), 32'h0);
    chk("disabled busy", 32'(rx_busy), 32'h0);
    rx_en = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    fork
      send_frame(8'h81, 1'b1);
      begin
        tick(40);
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    tick(2);
    chk("en count", 32'(rx_count), 32'h3);
    pop_expect(8'h00);
    pop_expect(8'hFF);
    pop_expect(8'h81);

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
